// File: rtl/ppwm_seq.sv
// Multi-channel programmable PWM: a serial loader fills a small instruction memory,
// and a looping sequencer computes duty values committed glitch-free at period start.
module ppwm_seq #(
   parameter int CHANNELS = 2,
   parameter int PWM_W    = 10,
   parameter int INSTR_W  = 6,
   parameter int DEPTH    = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                data_i,
   output logic [CHANNELS-1:0] data_o,
   output logic                programmed_o,
   output logic                period_start_o
);

   localparam int ARG_W = INSTR_W - 2;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int BW    = $clog2(INSTR_W);
   localparam int SW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   typedef enum logic {L_IDLE, L_SHIFT} loadState_e;
   typedef enum logic {S_RUN, S_WAIT} seqState_e;
   typedef enum logic [1:0] {OP_SEL = 2'b00, OP_LD = 2'b01, OP_ADD = 2'b10, OP_WAIT = 2'b11} op_e;

   loadState_e          loadState_q, loadState_d;
   logic [BW-1:0]       bitCnt_q, bitCnt_d;
   logic [INSTR_W-2:0]  shift_q, shift_d;
   logic [AW-1:0]       wptr_q, wptr_d;
   logic                programmed_q, programmed_d;
   logic                wordDone;
   logic [INSTR_W-1:0]  wordIn;
   logic [INSTR_W-1:0]  mem_q [DEPTH];

   seqState_e           seqState_q, seqState_d;
   logic [AW-1:0]       pc_q, pc_d;
   logic [PWM_W-1:0]    acc_q, acc_d;
   logic [SW-1:0]       sel_q, sel_d;
   logic [ARG_W:0]      wcnt_q, wcnt_d;
   logic [PWM_W-1:0]    counter_q;
   logic [PWM_W-1:0]    shadow_q [CHANNELS];
   logic [PWM_W-1:0]    duty_q [CHANNELS];
   logic [PWM_W-1:0]    dutyEff [CHANNELS];
   logic [CHANNELS-1:0] data_q;
   logic                periodStart;
   logic                shadowWe;
   logic [INSTR_W-1:0]  instr;
   op_e                 op;
   logic [ARG_W-1:0]    arg;
   logic [PWM_W+1:0]    sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) loadState_q <= L_IDLE;
      else        loadState_q <= loadState_d;
   end

   always_comb begin
      loadState_d = loadState_q;
      case (loadState_q)
         L_IDLE:  if (data_i && !programmed_q) loadState_d = L_SHIFT;
         L_SHIFT: if (bitCnt_q == BW'(INSTR_W - 1)) loadState_d = L_IDLE;
         default: loadState_d = L_IDLE;
      endcase
   end

   // The last data bit goes straight into memory so a start bit can follow it immediately.
   always_comb begin
      wordDone     = (loadState_q == L_SHIFT) && (bitCnt_q == BW'(INSTR_W - 1));
      wordIn       = {shift_q, data_i};
      bitCnt_d     = '0;
      shift_d      = shift_q;
      wptr_d       = wptr_q;
      programmed_d = programmed_q;
      if (loadState_q == L_SHIFT) begin
         bitCnt_d = bitCnt_q + 1'b1;
         shift_d  = {shift_q[INSTR_W-3:0], data_i};
      end
      if (wordDone) begin
         bitCnt_d = '0;
         wptr_d   = wptr_q + 1'b1;
         if (wptr_q == AW'(DEPTH - 1)) programmed_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bitCnt_q     <= '0;
         shift_q      <= '0;
         wptr_q       <= '0;
         programmed_q <= 1'b0;
      end else begin
         bitCnt_q     <= bitCnt_d;
         shift_q      <= shift_d;
         wptr_q       <= wptr_d;
         programmed_q <= programmed_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wordDone) mem_q[wptr_q] <= wordIn;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) seqState_q <= S_RUN;
      else        seqState_q <= seqState_d;
   end

   always_comb begin
      seqState_d = seqState_q;
      case (seqState_q)
         S_RUN:   if (programmed_q && op == OP_WAIT) seqState_d = S_WAIT;
         S_WAIT:  if (periodStart && wcnt_q == {{ARG_W{1'b0}}, 1'b1}) seqState_d = S_RUN;
         default: seqState_d = S_RUN;
      endcase
   end

   // A pulse coinciding with WAIT issue is not counted because the sequencer is still in RUN.
   always_comb begin
      instr       = mem_q[pc_q];
      op          = op_e'(instr[INSTR_W-1 -: 2]);
      arg         = instr[ARG_W-1:0];
      periodStart = programmed_q && (counter_q == '0);
      sum         = {2'b00, acc_q} + {{(PWM_W + 2 - ARG_W){arg[ARG_W-1]}}, arg};
      pc_d        = pc_q;
      acc_d       = acc_q;
      sel_d       = sel_q;
      wcnt_d      = wcnt_q;
      shadowWe    = 1'b0;
      if (programmed_q && seqState_q == S_RUN) begin
         case (op)
            OP_SEL: begin
               sel_d = SW'(32'(arg) % CHANNELS);
               pc_d  = pc_q + 1'b1;
            end
            OP_LD: begin
               acc_d = PWM_W'(arg) << (PWM_W - ARG_W);
               pc_d  = pc_q + 1'b1;
            end
            OP_ADD: begin
               if (sum[PWM_W+1])    acc_d = '0;
               else if (sum[PWM_W]) acc_d = '1;
               else                 acc_d = sum[PWM_W-1:0];
               pc_d = pc_q + 1'b1;
            end
            OP_WAIT: begin
               shadowWe = 1'b1;
               wcnt_d   = {1'b0, arg} + 1'b1;
            end
            default: ;
         endcase
      end else if (seqState_q == S_WAIT && periodStart) begin
         wcnt_d = wcnt_q - 1'b1;
         if (wcnt_q == {{ARG_W{1'b0}}, 1'b1}) pc_d = pc_q + 1'b1;
      end
      for (int c = 0; c < CHANNELS; c++) begin
         dutyEff[c] = periodStart ? shadow_q[c] : duty_q[c];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q   <= '0;
         acc_q  <= '0;
         sel_q  <= '0;
         wcnt_q <= '0;
      end else begin
         pc_q   <= pc_d;
         acc_q  <= acc_d;
         sel_q  <= sel_d;
         wcnt_q <= wcnt_d;
      end
   end

   // The compare uses the incoming duty on the period-start cycle so every period is whole.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         counter_q <= '0;
         data_q    <= '0;
         for (int c = 0; c < CHANNELS; c++) begin
            shadow_q[c] <= '0;
            duty_q[c]   <= '0;
         end
      end else begin
         counter_q <= programmed_q ? counter_q + 1'b1 : '0;
         for (int c = 0; c < CHANNELS; c++) begin
            if (shadowWe && sel_q == SW'(c)) shadow_q[c] <= acc_q;
            if (periodStart)                 duty_q[c]   <= shadow_q[c];
            data_q[c] <= programmed_q && (counter_q < dutyEff[c]);
         end
      end
   end

   assign data_o         = data_q;
   assign programmed_o   = programmed_q;
   assign period_start_o = periodStart;

endmodule
